// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module  : uart_rx_ctrl
// Purpose : Configuration owner and buffered byte/error front-end for UART_RX.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
  parameter int         FIFO_DEPTH   = 8,
  parameter int         IDLE_BITS    = 2,
  parameter logic [5:0] PRESCALE_RST = 6'd8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_in,
  input  logic                          cfg_wr,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_typ,
  input  logic [5:0]                    cfg_prescale,
  output logic                          PAR_EN,
  output logic                          PAR_TYP,
  output logic [5:0]                    prescale,
  output logic                          cfg_pending,
  input  logic [7:0]                    rx_p_data,
  input  logic                          rx_data_valid,
  input  logic                          rx_par_err,
  input  logic                          rx_stp_err,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    par_err_cnt,
  output logic [7:0]                    stp_err_cnt,
  input  logic                          err_clr
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    QUIET  = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] quiet_cnt_q, quiet_cnt_d;
  logic [11:0] idle_thr;
  logic        idle_reached;

  logic        dv_prev_q, par_prev_q, stp_prev_q;
  logic        dv_rise_q, par_rise_q, stp_rise_q;
  logic        good_q;
  logic [7:0]  data_q;
  logic        dv_rise;
  logic        frame_evt;

  logic        sh_par_en_q, sh_par_en_d;
  logic        sh_par_typ_q, sh_par_typ_d;
  logic [5:0]  sh_prescale_q, sh_prescale_d;
  logic        pending_q, pending_d;
  logic        par_en_q, par_en_d;
  logic        par_typ_q, par_typ_d;
  logic [5:0]  prescale_q, prescale_d;
  logic        cfg_load;
  logic        cfg_apply;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           fifo_full;
  logic           fifo_nonempty;
  logic           push, pop, drop;

  logic        overflow_q, overflow_d;
  logic [7:0]  par_cnt_q, par_cnt_d;
  logic [7:0]  stp_cnt_q, stp_cnt_d;

  // ---------------------------------------------------------------------------
  // Line-idle qualification
  // ---------------------------------------------------------------------------
  assign idle_thr     = 12'(IDLE_BITS) * {6'd0, prescale_q};
  assign idle_reached = (quiet_cnt_q >= idle_thr);
  assign frame_evt    = dv_rise_q | par_rise_q | stp_rise_q;

  always_comb begin
    quiet_cnt_d = quiet_cnt_q;
    if (!rx_in) begin
      quiet_cnt_d = 12'd0;
    end else if (quiet_cnt_q != 12'hFFF) begin
      quiet_cnt_d = quiet_cnt_q + 12'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      QUIET: begin
        if (!rx_in) begin
          state_d = ACTIVE;
        end else if (idle_reached) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!rx_in) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // A frame that never produces an event is treated as aborted once the line has been high long enough.
        if (frame_evt || idle_reached) begin
          state_d = QUIET;
        end
      end
      default: state_d = QUIET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= QUIET;
      quiet_cnt_q <= 12'd0;
    end else begin
      state_q     <= state_d;
      quiet_cnt_q <= quiet_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver status edge detection
  // ---------------------------------------------------------------------------
  assign dv_rise = rx_data_valid & ~dv_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_prev_q  <= 1'b0;
      par_prev_q <= 1'b0;
      stp_prev_q <= 1'b0;
      dv_rise_q  <= 1'b0;
      par_rise_q <= 1'b0;
      stp_rise_q <= 1'b0;
      good_q     <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      dv_prev_q  <= rx_data_valid;
      par_prev_q <= rx_par_err;
      stp_prev_q <= rx_stp_err;
      dv_rise_q  <= dv_rise;
      par_rise_q <= rx_par_err & ~par_prev_q;
      stp_rise_q <= rx_stp_err & ~stp_prev_q;
      good_q     <= dv_rise & ~rx_par_err & ~rx_stp_err;
      if (dv_rise) begin
        data_q <= rx_p_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration shadow and idle-gated apply
  // ---------------------------------------------------------------------------
  assign cfg_load  = cfg_wr && (cfg_prescale != 6'd0);
  assign cfg_apply = (state_q == IDLE) && rx_in && pending_q;

  always_comb begin
    sh_par_en_d   = sh_par_en_q;
    sh_par_typ_d  = sh_par_typ_q;
    sh_prescale_d = sh_prescale_q;
    pending_d     = pending_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    prescale_d    = prescale_q;
    // Apply always takes the pre-edge shadow; a coincident write re-arms pending.
    if (cfg_apply) begin
      par_en_d   = sh_par_en_q;
      par_typ_d  = sh_par_typ_q;
      prescale_d = sh_prescale_q;
      pending_d  = 1'b0;
    end
    if (cfg_load) begin
      sh_par_en_d   = cfg_par_en;
      sh_par_typ_d  = cfg_par_typ;
      sh_prescale_d = cfg_prescale;
      pending_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_par_en_q   <= 1'b0;
      sh_par_typ_q  <= 1'b0;
      sh_prescale_q <= PRESCALE_RST;
      pending_q     <= 1'b0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      prescale_q    <= PRESCALE_RST;
    end else begin
      sh_par_en_q   <= sh_par_en_d;
      sh_par_typ_q  <= sh_par_typ_d;
      sh_prescale_q <= sh_prescale_d;
      pending_q     <= pending_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      prescale_q    <= prescale_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  assign fifo_full     = (count_q == DEPTH_C);
  assign fifo_nonempty = (count_q != '0);
  assign pop           = fifo_nonempty & out_ready;
  assign push          = good_q & (~fifo_full | pop);
  assign drop          = good_q & fifo_full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Error statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    overflow_d = overflow_q;
    par_cnt_d  = par_cnt_q;
    stp_cnt_d  = stp_cnt_q;
    if (err_clr) begin
      overflow_d = 1'b0;
      par_cnt_d  = 8'd0;
      stp_cnt_d  = 8'd0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
      end
      if (par_rise_q && (par_cnt_q != 8'hFF)) begin
        par_cnt_d = par_cnt_q + 8'd1;
      end
      if (stp_rise_q && (stp_cnt_q != 8'hFF)) begin
        stp_cnt_d = stp_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      par_cnt_q  <= 8'd0;
      stp_cnt_q  <= 8'd0;
    end else begin
      overflow_q <= overflow_d;
      par_cnt_q  <= par_cnt_d;
      stp_cnt_q  <= stp_cnt_d;
    end
  end

  assign PAR_EN      = par_en_q;
  assign PAR_TYP     = par_typ_q;
  assign prescale    = prescale_q;
  assign cfg_pending = pending_q;
  assign out_valid   = fifo_nonempty;
  assign out_data    = fifo_nonempty ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Purpose : Directed self-checking bench for uart_rx_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic       cfg_wr;
  logic       cfg_par_en;
  logic       cfg_par_typ;
  logic [5:0] cfg_prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       cfg_pending;
  logic [7:0] rx_p_data;
  logic       rx_data_valid;
  logic       rx_par_err;
  logic       rx_stp_err;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] par_err_cnt;
  logic [7:0] stp_err_cnt;
  logic       err_clr;

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl #(
    .FIFO_DEPTH  (8),
    .IDLE_BITS   (2),
    .PRESCALE_RST(6'd8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .cfg_wr       (cfg_wr),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_typ  (cfg_par_typ),
    .cfg_prescale (cfg_prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .prescale     (prescale),
    .cfg_pending  (cfg_pending),
    .rx_p_data    (rx_p_data),
    .rx_data_valid(rx_data_valid),
    .rx_par_err   (rx_par_err),
    .rx_stp_err   (rx_stp_err),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .par_err_cnt  (par_err_cnt),
    .stp_err_cnt  (stp_err_cnt),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start bit low for 4 cycles, then a one-cycle status pulse with the line high.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic se);
    rx_in = 1'b0;
    repeat (4) tick();
    rx_in         = 1'b1;
    rx_p_data     = d;
    rx_data_valid = 1'b1;
    rx_par_err    = pe;
    rx_stp_err    = se;
    tick();
    rx_data_valid = 1'b0;
    rx_par_err    = 1'b0;
    rx_stp_err    = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    logic held;
    rst_n         = 1'b0;
    rx_in         = 1'b1;
    cfg_wr        = 1'b0;
    cfg_par_en    = 1'b0;
    cfg_par_typ   = 1'b0;
    cfg_prescale  = 6'd0;
    rx_p_data     = 8'h00;
    rx_data_valid = 1'b0;
    rx_par_err    = 1'b0;
    rx_stp_err    = 1'b0;
    out_ready     = 1'b0;
    err_clr       = 1'b0;
    repeat (3) tick();

    chk("rst_par_en",   PAR_EN,      0);
    chk("rst_par_typ",  PAR_TYP,     0);
    chk("rst_prescale", prescale,    8);
    chk("rst_pending",  cfg_pending, 0);
    chk("rst_valid",    out_valid,   0);
    chk("rst_data",     out_data,    0);
    chk("rst_count",    fifo_count,  0);
    chk("rst_ovf",      overflow,    0);
    chk("rst_par_cnt",  par_err_cnt, 0);
    chk("rst_stp_cnt",  stp_err_cnt, 0);
    rst_n = 1'b1;

    // Idle qualification then a config write applied on the following edge.
    repeat (20) tick();
    cfg_wr = 1'b1; cfg_par_en = 1'b1; cfg_par_typ = 1'b1; cfg_prescale = 6'd8;
    tick();
    cfg_wr = 1'b0;
    chk("cfg1_pending_set", cfg_pending, 1);
    chk("cfg1_not_yet",     PAR_EN,      0);
    tick();
    chk("cfg1_par_en",   PAR_EN,      1);
    chk("cfg1_par_typ",  PAR_TYP,     1);
    chk("cfg1_prescale", prescale,    8);
    chk("cfg1_pending",  cfg_pending, 0);

    // A zero prescale write is ignored.
    cfg_wr = 1'b1; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_prescale = 6'd0;
    tick();
    cfg_wr = 1'b0;
    chk("cfg0_pending", cfg_pending, 0);
    tick();
    chk("cfg0_par_en", PAR_EN, 1);
    chk("cfg0_presc",  prescale, 8);

    // Config write during a frame waits for the line to re-qualify idle.
    rx_in = 1'b0;
    tick();
    cfg_wr = 1'b1; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_prescale = 6'd16;
    tick();
    cfg_wr = 1'b0;
    chk("cfg2_pending_set", cfg_pending, 1);
    repeat (2) tick();
    rx_in = 1'b1; rx_p_data = 8'h55; rx_data_valid = 1'b1; out_ready = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    chk("cfg2_held_at_evt", prescale, 8);
    tick();
    chk("cfg2_byte_valid", out_valid, 1);
    chk("cfg2_byte_data",  out_data,  8'h55);
    held = 1'b1;
    repeat (15) begin
      tick();
      held = held & (prescale == 6'd8) & (PAR_EN == 1'b1) & (cfg_pending == 1'b1);
    end
    chk("cfg2_held_window", held, 1);
    tick();
    chk("cfg2_prescale", prescale,    16);
    chk("cfg2_par_en",   PAR_EN,      0);
    chk("cfg2_par_typ",  PAR_TYP,     0);
    chk("cfg2_pending",  cfg_pending, 0);
    chk("cfg2_drained",  fifo_count,  0);
    out_ready = 1'b0;

    // Three buffered frames, then drained in order.
    send_frame(8'h09, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("buf3_count", fifo_count, 3);
    out_ready = 1'b1;
    chk("buf3_b0", out_data, 8'h09);
    tick();
    chk("buf3_b1", out_data, 8'hA5);
    tick();
    chk("buf3_b2", out_data, 8'h3C);
    chk("buf3_v2", out_valid, 1);
    tick();
    chk("buf3_empty", out_valid, 0);
    out_ready = 1'b0;

    // Overflow: nine frames into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag",  overflow,   1);
    chk("ovf_head",  out_data,   8'h10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr_flag",  overflow,   0);
    chk("ovf_clr_count", fifo_count, 8);
    out_ready = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 8; i++) begin
      held = held & (out_valid == 1'b1) & (out_data == 8'h10 + 8'(i));
      tick();
    end
    chk("ovf_order",  held,      1);
    chk("ovf_ninth_absent", out_valid, 0);
    out_ready = 1'b0;

    // Errored frames count but never enter the FIFO.
    send_frame(8'hAA, 1'b1, 1'b0);
    send_frame(8'hAB, 1'b1, 1'b0);
    send_frame(8'hBB, 1'b0, 1'b1);
    chk("err_par_cnt", par_err_cnt, 2);
    chk("err_stp_cnt", stp_err_cnt, 1);
    chk("err_count",   fifo_count,  0);
    repeat (300) begin
      rx_par_err = 1'b1;
      tick();
      rx_par_err = 1'b0;
      tick();
    end
    tick();
    chk("err_par_sat", par_err_cnt, 255);
    chk("err_stp_keep", stp_err_cnt, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_par", par_err_cnt, 0);
    chk("err_clr_stp", stp_err_cnt, 0);
    rx_par_err = 1'b1;
    tick();
    rx_par_err = 1'b0;
    err_clr    = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_prio", par_err_cnt, 0);
    tick();
    chk("err_clr_prio_hold", par_err_cnt, 0);

    // Asynchronous reset mid-frame with two buffered bytes.
    send_frame(8'h21, 1'b0, 1'b0);
    send_frame(8'h43, 1'b0, 1'b0);
    chk("rst2_pre_count", fifo_count, 2);
    chk("rst2_pre_presc", prescale,   16);
    rx_in = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("rst2_valid",   out_valid,   0);
    chk("rst2_count",   fifo_count,  0);
    chk("rst2_presc",   prescale,    8);
    chk("rst2_pending", cfg_pending, 0);
    rx_in = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_frame(8'h7E, 1'b0, 1'b0);
    chk("rst2_new_count", fifo_count, 1);
    chk("rst2_new_valid", out_valid,  1);
    chk("rst2_new_data",  out_data,   8'h7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sits beside UART_RX. It owns the receiver configuration (PAR_EN, PAR_TYP, prescale) and applies new settings only while the serial line is idle, so a frame is never sampled with mixed settings. It turns the receiver's frame events into a buffered valid/ready byte stream and keeps parity, stop and overflow error statistics for software.

Parameters:
FIFO_DEPTH, 8, byte FIFO depth; power of 2, range 2..64
IDLE_BITS, 2, consecutive high bit-times on rx_in that qualify the line as idle
PRESCALE_RST, 8, prescale value driven after reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_in  in  1  serial line, same net as UART_RX RX_IN
cfg_wr  in  1  1-cycle strobe; loads the cfg_* shadow registers
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type (1 = odd)
cfg_prescale  in  6  requested clocks per bit
PAR_EN  out  1  applied parity enable, to UART_RX
PAR_TYP  out  1  applied parity type, to UART_RX
prescale  out  6  applied clocks per bit, to UART_RX
cfg_pending  out  1  shadow written but not yet applied
rx_p_data  in  8  UART_RX P_DATA
rx_data_valid  in  1  UART_RX data_valid
rx_par_err  in  1  UART_RX par_err
rx_stp_err  in  1  UART_RX stp_err
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid && out_ready
fifo_count  out  log2(FIFO_DEPTH)+1  occupancy
overflow  out  1  sticky; a good frame was dropped because the FIFO was full
par_err_cnt  out  8  saturating parity-error count
stp_err_cnt  out  8  saturating stop-error count
err_clr  in  1  clears both counters and overflow

Behaviour:
- Reset values: PAR_EN=0, PAR_TYP=0, prescale=PRESCALE_RST, cfg_pending=0, out_valid=0, out_data=0, fifo_count=0, overflow=0, both counters=0, FSM=QUIET, quiet counter=0.
- Quiet counter: 12-bit, saturating. Clears on any cycle with rx_in=0 and increments on rx_in=1. Threshold = IDLE_BITS*prescale, using the applied prescale.
- FSM QUIET: go to ACTIVE if rx_in=0; go to IDLE when the counter reaches the threshold.
- FSM IDLE: go to ACTIVE if rx_in=0.
- FSM ACTIVE: go to QUIET on a frame event (rising edge of rx_data_valid, rx_par_err or rx_stp_err), or when the counter reaches the threshold (aborted frame).
- Config shadow: cfg_wr with cfg_prescale!=0 loads the shadow and sets cfg_pending. cfg_wr with cfg_prescale=0 is ignored entirely. A cfg_wr while already pending overwrites the shadow.
- Config apply: when the FSM is IDLE, rx_in=1 and cfg_pending=1, the shadow is copied to the outputs on the next edge and cfg_pending clears.
- Config apply in the same cycle as cfg_wr: the old shadow is applied, the new value is latched, and cfg_pending stays 1.
- Config during a frame: nothing is applied while in QUIET or ACTIVE.
- Frame capture: all rx_* status inputs are edge-detected with 1-cycle registered rising edges.
- Good frame: a data_valid rise with par_err=0 and stp_err=0 that cycle pushes rx_p_data into the FIFO. Latency is 2 cycles from the rx_data_valid rise to out_valid when the FIFO is empty.
- Errored frame: a par_err rise increments par_err_cnt and a stp_err rise increments stp_err_cnt. Both can increment in the same cycle. Errored data is never pushed.
- Counters saturate at 255. err_clr has priority over a simultaneous increment: result 0.
- FIFO: a push when full with no pop in that cycle is dropped and sets overflow. Push and pop when full: both happen and the count is unchanged. Push and pop when empty: the push succeeds and out_valid rises next cycle.
- FIFO invariants: out_data is stable while out_valid=1 && out_ready=0. Pointers wrap modulo FIFO_DEPTH.
- err_clr does not flush the FIFO.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Bytes in the FIFO are lost. The FSM re-qualifies idle before any config is applied.

Test Plan:
- Reset, rx_in held high for 16 cycles, cfg_wr {1,1,8} -> PAR_EN=1, PAR_TYP=1, prescale=8 one cycle after cfg_wr; cfg_pending back to 0.
- cfg_wr {0,0,16} issued mid-frame (rx_in low at start bit) -> outputs unchanged until rx_in has been high 16 cycles after the frame event, then applied; cfg_pending high for that whole window.
- Three good frames 0x09, 0xA5, 0x3C with out_ready=0 -> fifo_count=3; then out_ready=1 -> bytes delivered in order, one per cycle, with out_valid low after the third.
- FIFO_DEPTH=8, send 9 good frames with out_ready=0 -> fifo_count=8, overflow=1, the ninth byte absent; err_clr -> overflow=0, fifo_count=8.
- Two wrong-parity frames and one frame with stop bit=0 -> par_err_cnt=2, stp_err_cnt=1, fifo_count unchanged; 300 parity errors -> par_err_cnt=255.
- rst_n pulsed low mid-frame with 2 bytes buffered -> out_valid=0, fifo_count=0, prescale=8 immediately; the next full frame is received correctly.
